filtb_chan_sched: RTL and testbench

- Time-multiplexed scheduler for the long-term average (DML) update in the multi-channel ADPCM decoder's quantizer scale-factor adaptation.
- Holds one 14-bit DML state per channel and arbitrates round-robin between channel update requests.
- Runs one shared DML update datapath per grant and writes the result back.
- Sits between the per-channel FI generators and the downstream speed-control logic, which reads DML through a read port.

---
 rtl/filtb_chan_sched.sv | 171 +++++++++++++++++
 tb/tb_filtb_chan_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filtb_chan_sched.sv
// Round-robin scheduler sharing one DML (long-term average) update datapath across NCH channels.
// Optional per-channel clear input CLR is enabled by defining FILTB_SCHED_CLR_EN.
module filtb_chan_sched #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   REQ,
    input  logic [3*NCH-1:0] FI_IN,
    output logic [NCH-1:0]   GNT,
    output logic             DONE,
    output logic [CHW-1:0]   DONE_CH,
    output logic [13:0]      DML_OUT,
    output logic             BUSY,
    input  logic [CHW-1:0]   RD_CH,
    output logic [13:0]      RD_DML
`ifdef FILTB_SCHED_CLR_EN
    ,
    input  logic [NCH-1:0]   CLR
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [13:0]    dml_mem [NCH];
    logic [CHW-1:0] ptr;

    logic [CHW-1:0] ch_q;
    logic [2:0]     fi_q;
    logic [13:0]    dml_q;
    logic [13:0]    dmlp_q;

    logic           found;
    logic [CHW-1:0] pick;
    logic [2:0]     fi_pick;
    logic           load;
    logic           wr;

    logic [14:0]    dif;
    logic [13:0]    difsx;
    logic [13:0]    dmlp_c;

    // First requesting channel at or above the pointer, wrapping around.
    always_comb begin
        int unsigned idx;
        found   = 1'b0;
        pick    = '0;
        fi_pick = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = (32'(ptr) + i) % NCH;
            if (!found && REQ[idx]) begin
                found   = 1'b1;
                pick    = CHW'(idx);
                fi_pick = FI_IN[3*idx +: 3];
            end
        end
    end

    // The +32768 term vanishes modulo 2^15; DIFSX is DIF>>7 sign-extended to 14 bits.
    always_comb begin
        dif    = {1'b0, fi_q, 11'd0} - {1'b0, dml_q};
        difsx  = {{6{dif[14]}}, dif[14:7]};
        dmlp_c = difsx + dml_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        wr        = 1'b0;
        GNT       = '0;
        DONE      = 1'b0;
        DONE_CH   = '0;
        DML_OUT   = '0;
        BUSY      = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                BUSY      = 1'b1;
                state_nxt = WB;
            end
            WB: begin
                BUSY      = 1'b1;
                wr        = 1'b1;
                DONE      = 1'b1;
                DONE_CH   = ch_q;
                DML_OUT   = dmlp_q;
                GNT[ch_q] = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q   <= '0;
            fi_q   <= '0;
            dml_q  <= '0;
            dmlp_q <= '0;
        end else begin
            if (load) begin
                ch_q  <= pick;
                fi_q  <= fi_pick;
                dml_q <= dml_mem[pick];
            end
            if (state == CALC) begin
                dmlp_q <= dmlp_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (wr) begin
            ptr <= (32'(ch_q) == NCH - 1) ? '0 : ch_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                dml_mem[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (wr && ch_q == CHW'(k)) begin
                    dml_mem[k] <= dmlp_q;
                end
`ifdef FILTB_SCHED_CLR_EN
                // A clear overrides a same-cycle writeback to that channel.
                if (CLR[k]) begin
                    dml_mem[k] <= '0;
                end
`endif
            end
        end
    end

    always_comb begin
        RD_DML = '0;
        if (32'(RD_CH) < NCH) begin
            RD_DML = dml_mem[RD_CH];
        end
    end

endmodule

// File: tb/tb_filtb_chan_sched.sv
// Self-checking bench for filtb_chan_sched: directed cases plus randomized traffic against
// a transaction-timed reference model. Exercises CLR when FILTB_SCHED_CLR_EN is defined.
module tb_filtb_chan_sched;

    localparam int NCH = 4;
    localparam int CHW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   REQ;
    logic [3*NCH-1:0] FI_IN;
    logic [NCH-1:0]   GNT;
    logic             DONE;
    logic [CHW-1:0]   DONE_CH;
    logic [13:0]      DML_OUT;
    logic             BUSY;
    logic [CHW-1:0]   RD_CH;
    logic [13:0]      RD_DML;
`ifdef FILTB_SCHED_CLR_EN
    logic [NCH-1:0]   CLR;
`endif

    filtb_chan_sched #(.NCH(NCH), .CHW(CHW)) dut (
        .clk     (clk),
        .reset   (reset),
        .REQ     (REQ),
        .FI_IN   (FI_IN),
        .GNT     (GNT),
        .DONE    (DONE),
        .DONE_CH (DONE_CH),
        .DML_OUT (DML_OUT),
        .BUSY    (BUSY),
        .RD_CH   (RD_CH),
        .RD_DML  (RD_DML)
`ifdef FILTB_SCHED_CLR_EN
        ,
        .CLR     (CLR)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: stored averages, arbitration pointer and the in-flight transaction.
    int dml_m [NCH];
    int ptr_m       = 0;
    int edge_n      = 0;
    int free_edge   = 0;
    int done_edge   = -10;
    int commit_edge = -10;
    int wb_ch       = 0;
    int wb_val      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic int model_dmlp(input int fi, input int dml);
        int dif;
        int difsx;
        dif   = (fi * 2048 + 32768 - dml) % 32768;
        difsx = (dif >= 16384) ? (dif / 128 + 16128) : (dif / 128);
        return (difsx + dml) % 16384;
    endfunction

    function automatic int model_pick(input logic [NCH-1:0] req, input int ptr);
        for (int i = 0; i < NCH; i++) begin
            if (req[(ptr + i) % NCH]) return (ptr + i) % NCH;
        end
        return -1;
    endfunction

    task automatic step();
        int w;
        @(posedge clk);
        edge_n++;
        if (reset) begin
            for (int k = 0; k < NCH; k++) dml_m[k] = 0;
            ptr_m       = 0;
            free_edge   = edge_n + 1;
            done_edge   = -10;
            commit_edge = -10;
        end else begin
            if (edge_n >= free_edge && REQ != '0) begin
                w           = model_pick(REQ, ptr_m);
                wb_ch       = w;
                wb_val      = model_dmlp(int'(FI_IN[3*w +: 3]), dml_m[w]);
                done_edge   = edge_n + 1;
                commit_edge = edge_n + 2;
                free_edge   = edge_n + 3;
            end
            if (edge_n == commit_edge) begin
                dml_m[wb_ch] = wb_val;
                ptr_m        = (wb_ch + 1) % NCH;
            end
`ifdef FILTB_SCHED_CLR_EN
            for (int k = 0; k < NCH; k++) if (CLR[k]) dml_m[k] = 0;
`endif
        end
        #1;
        chk("done",    DONE,    edge_n == done_edge);
        chk("gnt",     GNT,     (edge_n == done_edge) ? (1 << wb_ch) : 0);
        chk("done_ch", DONE_CH, (edge_n == done_edge) ? wb_ch : 0);
        chk("dml_out", DML_OUT, (edge_n == done_edge) ? wb_val : 0);
        chk("busy",    BUSY,    edge_n == done_edge || edge_n == done_edge - 1);
        chk("rd_dml",  RD_DML,  dml_m[RD_CH]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        REQ   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic serve(input int ch, input int fi, input int exp_val);
        bit seen;
        seen = 1'b0;
        REQ = '0;
        REQ[ch] = 1'b1;
        FI_IN[3*ch +: 3] = 3'(fi);
        for (int k = 1; k <= 6 && !seen; k++) begin
            step();
            if (DONE) begin
                seen = 1'b1;
                chk("latency", k, 2);
                chk("dir_val", DML_OUT, exp_val);
            end
        end
        chk("served", seen, 1'b1);
        REQ = '0;
        step();
    endtask

    initial begin
        int gnt_seq [8];
        int gnt_edge [8];
        int val_seq [8];
        int n_gnt;
        bit seen;

        reset = 1'b1;
        REQ   = '0;
        FI_IN = '0;
        RD_CH = '0;
`ifdef FILTB_SCHED_CLR_EN
        CLR   = '0;
`endif
        do_reset();
        for (int i = 0; i < NCH; i++) begin
            RD_CH = CHW'(i);
            step();
            chk("rst_rd", RD_DML, 0);
        end
        chk("rst_gnt", GNT, 0);
        chk("rst_busy", BUSY, 0);

        RD_CH = '0;
        serve(0, 7, 112);
        serve(0, 7, 223);
        RD_CH = 2'd1;
        serve(1, 7, 112);
        serve(1, 0, 111);
        chk("rd_ch1", RD_DML, 111);

        // All channels requesting: strict rotation, one grant every 3 cycles.
        do_reset();
        FI_IN = 12'h249;
        REQ   = '1;
        n_gnt = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            if (DONE && n_gnt < 8) begin
                gnt_seq[n_gnt]  = int'(GNT);
                gnt_edge[n_gnt] = edge_n;
                val_seq[n_gnt]  = int'(DML_OUT);
                n_gnt++;
            end
        end
        chk("rr_count", n_gnt, 5);
        for (int i = 0; i < 5 && i < n_gnt; i++) begin
            chk("rr_gnt", gnt_seq[i], 1 << (i % NCH));
            if (i > 0) chk("rr_gap", gnt_edge[i] - gnt_edge[i-1], 3);
            if (i < NCH) chk("rr_val", val_seq[i], 16);
        end
        REQ = '0;
        step();
        step();

        // Reset during CALC of a channel-2 update aborts it.
        do_reset();
        REQ = 4'b0100;
        FI_IN[8:6] = 3'd7;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_done", DONE, 0);
        REQ = 4'b0101;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            step();
            if (DONE) begin
                seen = 1'b1;
                chk("abort_first_ch", DONE_CH, 0);
            end
        end
        chk("abort_served", seen, 1'b1);
        REQ   = '0;
        RD_CH = 2'd2;
        step();
        chk("abort_dml2", RD_DML, 0);

`ifdef FILTB_SCHED_CLR_EN
        do_reset();
        RD_CH = '0;
        REQ   = 4'b0001;
        FI_IN[2:0] = 3'd7;
        step();
        step();
        chk("clr_done", DONE, 1);
        chk("clr_dmlout", DML_OUT, 112);
        CLR = 4'b0001;
        REQ = '0;
        step();
        CLR = '0;
        chk("clr_rd", RD_DML, 0);
`endif

        // Randomized traffic honouring the hold-until-grant protocol.
        do_reset();
        REQ = '0;
        for (int c = 0; c < 800; c++) begin
            if (edge_n == done_edge) REQ[wb_ch] = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                if (!REQ[k] && $urandom_range(3) == 0) begin
                    REQ[k] = 1'b1;
                    FI_IN[3*k +: 3] = 3'($urandom_range(7));
                end
            end
            RD_CH = CHW'($urandom_range(NCH - 1));
`ifdef FILTB_SCHED_CLR_EN
            CLR = ($urandom_range(15) == 0) ? NCH'($urandom) : '0;
`endif
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
